// File: rtl/serial_frame_rx.sv
// -----------------------------------------------------------------------------
// serial_frame_rx
// Receiving end of the 1-bit serial link. Samples one bit per rising clock
// edge, detects the start bit, shifts in DATA_W data bits LSB-first, checks an
// optional even-parity bit and the stop bit, and reports the result with a
// one-cycle pulse. Everything lives in the clk domain; all outputs registered.
//
// Parameters
//   DATA_W     data bits per frame (>= 1)
//   PARITY_EN  1: one even-parity bit follows the data, 0: no parity bit
//
// Ports
//   clk        rising-edge clock, one serial bit sampled per edge
//   reset      synchronous, active-high reset (wins over everything)
//   in         serial line, idle = 1, start bit = 0
//   out_data   last correctly received word (bit 0 = first data bit received)
//   out_valid  1-cycle pulse: out_data updated by a good frame
//   frame_err  1-cycle pulse: frame rejected (bad parity and/or bad stop bit)
//   busy       1 while the receiver is inside a frame
// -----------------------------------------------------------------------------
module serial_frame_rx #(
   parameter int DATA_W    = 8,
   parameter bit PARITY_EN = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   output logic              frame_err,
   output logic              busy
);

   localparam int CNT_W = $clog2(DATA_W + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_DATA   = 2'd1,
      S_PARITY = 2'd2,
      S_STOP   = 2'd3
   } state_t;

   state_t              state_q;
   logic [CNT_W-1:0]    cnt_q;
   logic [DATA_W-1:0]   shift_q;
   logic                par_bad_q;
   logic [DATA_W-1:0]   out_data_q;
   logic                out_valid_q;
   logic                frame_err_q;
   logic                busy_q;

   // New bit enters at the MSB so after DATA_W shifts the first bit sits at bit 0.
   function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] word,
                                                  input logic            bit_in);
      logic [DATA_W-1:0] tmp;
      tmp             = word >> 1;
      tmp[DATA_W-1]   = bit_in;
      return tmp;
   endfunction

   // XOR reduction of a word: 1 when the word holds an odd number of ones.
   function automatic logic odd_ones(input logic [DATA_W-1:0] word);
      return ^word;
   endfunction

   // Receiver FSM together with its registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         shift_q     <= '0;
         par_bad_q   <= 1'b0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         frame_err_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         out_valid_q <= 1'b0;
         frame_err_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (!in) begin
                  state_q   <= S_DATA;
                  cnt_q     <= '0;
                  par_bad_q <= 1'b0;
                  busy_q    <= 1'b1;
               end else begin
                  state_q   <= S_IDLE;
                  busy_q    <= 1'b0;
               end
            end
            S_DATA: begin
               shift_q <= shift_in(shift_q, in);
               // Counter tops out at DATA_W, so it never wraps inside a frame.
               cnt_q   <= cnt_q + CNT_W'(1);
               if (cnt_q == CNT_LAST) begin
                  state_q <= PARITY_EN ? S_PARITY : S_STOP;
               end else begin
                  state_q <= S_DATA;
               end
            end
            S_PARITY: begin
               // Even parity: data ones plus parity bit must be even.
               par_bad_q <= in ^ odd_ones(shift_q);
               state_q   <= S_STOP;
            end
            S_STOP: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
               // Parity and stop errors collapse into a single error pulse.
               if (in && !par_bad_q) begin
                  out_data_q  <= shift_q;
                  out_valid_q <= 1'b1;
               end else begin
                  frame_err_q <= 1'b1;
               end
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign frame_err = frame_err_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_serial_frame_rx.sv
// -----------------------------------------------------------------------------
// tb_serial_frame_rx
// Two receivers share clock and reset: dut_a (DATA_W=8, parity on) and dut_b
// (DATA_W=8, parity off). A frame-level model collects the bits of each frame
// after the start bit and judges the frame once all of them have arrived.
// Every cycle both receivers are compared against the model; directed cases
// also pin outputs and the model to hand-computed literals.
// -----------------------------------------------------------------------------
module tb_serial_frame_rx;

   localparam int DW = 8;

   logic          clk;
   logic          reset;
   logic          in_a, in_b;
   logic [DW-1:0] od_a, od_b;
   logic          val_a, val_b, err_a, err_b, busy_a, busy_b;

   int errors = 0;
   int checks = 0;
   bit chk_en = 1'b0;

   // Frame-level model state, index 0 = dut_a, 1 = dut_b.
   logic [DW-1:0] e_data [2];
   logic          e_val  [2];
   logic          e_err  [2];
   logic          e_busy [2];
   bit            m_on   [2];
   int            m_n    [2];
   logic [31:0]   m_bits [2];

   serial_frame_rx #(.DATA_W(DW), .PARITY_EN(1'b1)) dut_a (
      .clk(clk), .reset(reset), .in(in_a),
      .out_data(od_a), .out_valid(val_a), .frame_err(err_a), .busy(busy_a));

   serial_frame_rx #(.DATA_W(DW), .PARITY_EN(1'b0)) dut_b (
      .clk(clk), .reset(reset), .in(in_b),
      .out_data(od_b), .out_valid(val_b), .frame_err(err_b), .busy(busy_b));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Advance the model by one sampled bit per receiver.
   task automatic model_step(input logic rst, input logic a, input logic b);
      for (int i = 0; i < 2; i++) begin
         logic          x;
         int            par;
         int            flen;
         logic [DW-1:0] d;
         bit            good;
         x    = (i == 0) ? a : b;
         par  = (i == 0) ? 1 : 0;
         flen = DW + par + 1;          // bits after the start bit, incl. stop
         if (rst) begin
            e_data[i] = '0; e_val[i] = 1'b0; e_err[i] = 1'b0; e_busy[i] = 1'b0;
            m_on[i] = 1'b0; m_n[i] = 0; m_bits[i] = '0;
         end else begin
            e_val[i] = 1'b0;
            e_err[i] = 1'b0;
            if (!m_on[i]) begin
               if (x == 1'b0) begin
                  m_on[i] = 1'b1;
                  m_n[i]  = 0;
               end
            end else begin
               m_bits[i][m_n[i]] = x;
               m_n[i]++;
               if (m_n[i] == flen) begin
                  d    = m_bits[i][DW-1:0];
                  good = (m_bits[i][flen-1] == 1'b1) &&
                         (par == 0 || (($countones(d) + int'(m_bits[i][DW])) % 2 == 0));
                  if (good) begin
                     e_data[i] = d;
                     e_val[i]  = 1'b1;
                  end else begin
                     e_err[i]  = 1'b1;
                  end
                  m_on[i] = 1'b0;
               end
            end
            e_busy[i] = m_on[i];
         end
      end
   endtask

   task automatic send_bit(input logic a, input logic b);
      in_a = a;
      in_b = b;
      @(posedge clk);
      model_step(reset, a, b);
      #2;
   endtask

   // Parity-enabled frame on line A; line B idles or carries random bits.
   task automatic send_frame_a(input logic [DW-1:0] d, input logic par_flip,
                               input logic stop, input bit rnd_b);
      logic [DW+2:0] bits;
      bits[0] = 1'b0;
      for (int j = 0; j < DW; j++) bits[j+1] = d[j];
      bits[DW+1] = (^d) ^ par_flip;
      bits[DW+2] = stop;
      for (int j = 0; j < DW + 3; j++)
         send_bit(bits[j], rnd_b ? 1'($urandom_range(1)) : 1'b1);
   endtask

   task automatic send_frame_b(input logic [DW-1:0] d, input logic stop);
      send_bit(1'b1, 1'b0);
      for (int j = 0; j < DW; j++) send_bit(1'b1, d[j]);
      send_bit(1'b1, stop);
   endtask

   // Cycle-by-cycle comparison of both receivers against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         check("a_data",  32'(od_a),   32'(e_data[0]));
         check("a_valid", 32'(val_a),  32'(e_val[0]));
         check("a_err",   32'(err_a),  32'(e_err[0]));
         check("a_busy",  32'(busy_a), 32'(e_busy[0]));
         check("b_data",  32'(od_b),   32'(e_data[1]));
         check("b_valid", 32'(val_b),  32'(e_val[1]));
         check("b_err",   32'(err_b),  32'(e_err[1]));
         check("b_busy",  32'(busy_b), 32'(e_busy[1]));
      end
   end

   initial begin
      reset = 1'b1;
      in_a  = 1'b1;
      in_b  = 1'b1;
      // 1. reset, then idle line
      send_bit(1'b1, 1'b1);
      chk_en = 1'b1;
      send_bit(1'b1, 1'b1);
      reset = 1'b0;
      for (int k = 0; k < 5; k++) begin
         send_bit(1'b1, 1'b1);
         check("idle_data", 32'(od_a), 32'h00);
         check("idle_busy", 32'(busy_a), 32'h0);
      end

      // 2. good 0xA5 frame
      send_frame_a(8'hA5, 1'b0, 1'b1, 1'b0);
      check("a5_valid", 32'(val_a), 32'h1);
      check("a5_data",  32'(od_a), 32'hA5);
      check("a5_model", 32'(e_data[0]), 32'hA5);
      send_bit(1'b1, 1'b1);
      check("a5_pulse_end", 32'(val_a), 32'h0);

      // 3. same frame, parity flipped
      send_frame_a(8'hA5, 1'b1, 1'b1, 1'b0);
      check("par_err",   32'(err_a), 32'h1);
      check("par_valid", 32'(val_a), 32'h0);
      check("par_hold",  32'(od_a),  32'hA5);

      // 4. back-to-back frames with no gap
      send_frame_a(8'h3C, 1'b0, 1'b1, 1'b0);
      check("b2b_1", 32'({val_a, od_a}), 32'h13C);
      send_frame_a(8'h3C, 1'b0, 1'b1, 1'b0);
      check("b2b_2", 32'({val_a, od_a}), 32'h13C);
      send_frame_a(8'hFF, 1'b0, 1'b1, 1'b0);
      check("b2b_3", 32'({val_a, od_a}), 32'h1FF);

      // 5. reset in the middle of a 0x81 frame, then 0x12
      send_bit(1'b0, 1'b1);
      send_bit(1'b1, 1'b1);
      send_bit(1'b0, 1'b1);
      send_bit(1'b0, 1'b1);
      send_bit(1'b0, 1'b1);
      reset = 1'b1;
      send_bit(1'b1, 1'b1);
      reset = 1'b0;
      check("abort_data", 32'(od_a), 32'h00);
      check("abort_busy", 32'(busy_a), 32'h0);
      for (int k = 0; k < 8; k++) begin
         send_bit(1'b1, 1'b1);
         check("abort_nopulse", 32'({val_a, err_a}), 32'h0);
      end
      send_frame_a(8'h12, 1'b0, 1'b1, 1'b0);
      check("after_rst", 32'({val_a, od_a}), 32'h112);

      // 6. no-parity receiver, 0x7E with a bad stop bit
      send_frame_b(8'h7E, 1'b0);
      check("np_err",   32'(err_b), 32'h1);
      check("np_valid", 32'(val_b), 32'h0);
      check("np_busy",  32'(busy_b), 32'h0);
      check("np_model", 32'(e_err[1]), 32'h1);
      send_bit(1'b1, 1'b1);
      check("np_idle", 32'({busy_b, err_b}), 32'h0);
      send_frame_b(8'h7E, 1'b1);
      check("np_good", 32'({val_b, od_b}), 32'h17E);

      // Randomized frames on A, random bit stream on B, occasional resets.
      for (int it = 0; it < 200; it++) begin
         if ($urandom_range(39) == 0) begin
            reset = 1'b1;
            send_bit(1'($urandom_range(1)), 1'($urandom_range(1)));
            reset = 1'b0;
         end else begin
            send_frame_a(8'($urandom), ($urandom_range(5) == 0),
                         ($urandom_range(6) != 0), 1'b1);
            for (int g = $urandom_range(2); g > 0; g--)
               send_bit(1'b1, 1'($urandom_range(1)));
         end
      end

      @(negedge clk);
      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
